// File: rtl/alu_32b.sv
//==============================================================================
// Module   : alu_32b
// Purpose  : Registered add/sub/and/or ALU; result appears one clock after
//            the operands are sampled.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_32b #(
    parameter int WIDTH = 16
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_OR  = 2'b11;

    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] r_y;

    // Subtract shares the adder form: A + ~B + 1, with carry/borrow dropped.
    always_comb begin
        w_r = '0;
        unique case (Op)
            c_OP_ADD: w_r = A + B;
            c_OP_SUB: w_r = A + ~B + {{(WIDTH-1){1'b0}}, 1'b1};
            c_OP_AND: w_r = A & B;
            c_OP_OR:  w_r = A | B;
            default:  w_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y <= '0;
        end else begin
            r_y <= w_r;
        end
    end

    assign y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_alu_32b.sv
//==============================================================================
// Module   : tb_alu_32b
// Purpose  : Directed and random checks of alu_32b against an arithmetic model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_32b;

    logic [15:0] y;
    logic [15:0] A;
    logic [15:0] B;
    logic        clk;
    logic        reset;
    logic [1:0]  Op;

    int n_checks = 0;
    int n_fail   = 0;

    alu_32b #(.WIDTH(16)) dut (
        .y     (y),
        .A     (A),
        .B     (B),
        .clk   (clk),
        .reset (reset),
        .Op    (Op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        int unsigned t;
        case (op)
            2'd0:    t = (int'(a) + int'(b)) % 65536;
            2'd1:    t = (int'(a) - int'(b) + 65536) % 65536;
            2'd2:    t = int'(a & b);
            default: t = int'(a | b);
        endcase
        return t[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, check just after the following rising edge.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic [15:0] exp);
        @(negedge clk);
        A = a; B = b; Op = op;
        @(posedge clk);
        #1;
        check(tag, y, exp);
    endtask

    initial begin
        logic [15:0] ra, rb, hold;
        logic [1:0]  rop;

        reset = 1'b1; A = 16'h1234; B = 16'h1111; Op = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", y, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", y, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", y, 16'h2345);

        step("add_wrap",   16'hFFFF, 16'h0001, 2'b00, 16'h0000);
        step("add_sign",   16'h7FFF, 16'h0001, 2'b00, 16'h8000);
        step("sub_basic",  16'h0005, 16'h0003, 2'b01, 16'h0002);
        step("sub_wrap",   16'h0000, 16'h0001, 2'b01, 16'hFFFF);
        step("sub_equal",  16'hABCD, 16'hABCD, 2'b01, 16'h0000);
        step("and_op",     16'hF0F0, 16'hFF00, 2'b10, 16'hF000);
        step("or_op",      16'hF0F0, 16'hFF00, 2'b11, 16'hFFF0);
        step("or_zero",    16'h0000, 16'h0000, 2'b11, 16'h0000);

        // Mid-cycle input change must not reach y before the next edge.
        step("reg_base",   16'h0100, 16'h0023, 2'b00, 16'h0123);
        #2;
        A = 16'hFFFF; B = 16'h00FF; Op = 2'b10;
        #1;
        check("reg_midcycle", y, 16'h0123);
        @(posedge clk);
        #1;
        check("reg_next_edge", y, 16'h00FF);

        step("b2b_add", 16'h000C, 16'h000A, 2'b00, 16'h0016);
        step("b2b_sub", 16'h000C, 16'h000A, 2'b01, 16'h0002);
        step("b2b_and", 16'h000C, 16'h000A, 2'b10, 16'h0008);
        step("b2b_or",  16'h000C, 16'h000A, 2'b11, 16'h000E);

        for (int i = 0; i < 200; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 2'($urandom_range(0, 3));
            step("random", ra, rb, rop, model(ra, rb, rop));
        end

        // Reset dropped between edges while a stream is running.
        step("stream_pre", 16'h4000, 16'h0002, 2'b01, 16'h3FFE);
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Op = 2'b00;
        #1;
        reset = 1'b0;
        #1;
        check("midrun_reset_async", y, 16'h0000);
        @(posedge clk);
        #1;
        check("midrun_reset_hold", y, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_release", y, 16'h3333);

        for (int i = 0; i < 50; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 2'($urandom_range(0, 3));
            step("random_post", ra, rb, rop, model(ra, rb, rop));
        end
        hold = model(ra, rb, rop);
        @(posedge clk);
        #1;
        check("hold_same_inputs", y, hold);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_32b.md
# alu_32b

Registered 16-bit, four-function arithmetic/logic unit for the datapath. It combinationally computes one of add, subtract, bitwise AND or bitwise OR on operands `A` and `B`, as selected by `Op`. The result is captured in an output register on each rising clock edge. The module name keeps its historical `_32b` suffix; the datapath width is 16 bits.

## Interface
- `WIDTH`, default 16: operand and result width. All behaviour below is stated for `WIDTH` = 16.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. Low clears the output register immediately.
- `y`, output, 16 bits: registered ALU result.
- `A`, input, 16 bits: operand A.
- `B`, input, 16 bits: operand B.
- `Op`, input, 2 bits: operation select.
- Positional port order: `y, A, B, clk, reset, Op`.

## Operation
- Combinational stage computes `r` from the current `A`, `B` and `Op`:
  - `Op` = 2'b00: `r` = A + B, modulo 2^16. Carry-out is discarded.
  - `Op` = 2'b01: `r` = A − B, modulo 2^16. Two's complement, implemented as A + ~B + 1. Borrow is discarded.
  - `Op` = 2'b10: `r` = A & B, bitwise.
  - `Op` = 2'b11: `r` = A | B, bitwise.
- Operands are unsigned bit vectors. Overflow wraps silently; no flags are exported.
- The output register loads `r` on every rising `clk` edge while `reset` is high. There is no enable; `y` always reflects the last sampled inputs.
- If `Op`, `A` or `B` is X or Z at a sampling edge, the captured `y` is don't-care. Verification must not check it.

## Timing
- Reset: when `reset` falls, `y` goes to 16'h0000 asynchronously, with no clock needed. `y` holds 0 while `reset` stays low.
- Reset release: the first rising edge with `reset` high loads `r`.
- Reset asserted mid-operation: any pending result is lost and `y` becomes 0 immediately.
- Latency: one cycle. Inputs are sampled at rising edge N and appear on `y` right after edge N.
- Input changes between edges have no effect on `y` until the next rising edge. There is no combinational path from any input to `y`.
- The `A`/`B`/`Op` values present at the edge are the ones captured. A change coincident with the edge is a setup violation; benches must change stimulus away from the rising edge.
- Throughput: one operation per cycle, and `Op` may change every cycle.

## Test plan
- Reset: drive `reset` = 0 with `A` = 16'h1234, `B` = 16'h1111, `Op` = 00 → `y` = 16'h0000 immediately and across edges. Release reset → `y` = 16'h2345 after the next rising edge.
- Add wrap: `A` = 16'hFFFF, `B` = 16'h0001, `Op` = 00 → `y` = 16'h0000 after one edge. Separately, `A` = 16'h7FFF, `B` = 16'h0001 → 16'h8000.
- Subtract: `A` = 16'h0005, `B` = 16'h0003, `Op` = 01 → 16'h0002. `A` = 16'h0000, `B` = 16'h0001 → 16'hFFFF. `A` = `B` = 16'hABCD → 16'h0000.
- Logic ops: `A` = 16'hF0F0, `B` = 16'hFF00. `Op` = 10 → 16'hF000; `Op` = 11 → 16'hFFF0. All-zero operands with `Op` = 11 → 16'h0000.
- Registration: change `A`/`B`/`Op` mid-cycle → `y` unchanged until the next rising edge. Back-to-back `Op` sequence 00, 01, 10, 11 with `A` = 16'h000C, `B` = 16'h000A → `y` = 16'h0016, 16'h0002, 16'h0008, 16'h000E on consecutive edges.
- Mid-run reset: assert `reset` low between edges during a stream → `y` = 0 without a clock edge, then normal results resume on the first edge after release.
